// File: rtl/fp_wb_arb_pkg.sv
// Shared types for the FP regfile write-back arbiter.
//   fp_wb_src_e    : which producer owns the write port this cycle
//   fp_wb_entry_s  : {rd, data} write record at the default FP widths
//   fp_wb_clears() : whether a grant from a source also clears the scoreboard
package fp_wb_arb_pkg;

  localparam int unsigned fp_wb_data_width_gp     = 32;
  localparam int unsigned fp_wb_reg_addr_width_gp = 5;

  typedef enum logic [1:0] {
    e_wb_float,
    e_wb_fdiv,
    e_wb_rload,
    e_wb_none
  } fp_wb_src_e;

  typedef struct packed {
    logic [fp_wb_reg_addr_width_gp-1:0] rd;
    logic [fp_wb_data_width_gp-1:0]     data;
  } fp_wb_entry_s;

  // Float results are covered by pipeline forwarding; only long-latency
  // producers own a scoreboard bit that must be released on write-back.
  function automatic logic fp_wb_clears(input fp_wb_src_e src);
    return (src == e_wb_fdiv) || (src == e_wb_rload);
  endfunction

endpackage

// File: rtl/fp_wb_rload_fifo.sv
// Circular buffer for remote float-load responses.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset (pointers only)
//   v_i, data_i      : push request and entry
//   ready_o          : not full
//   v_o, data_o      : head valid and head entry
//   yumi_i           : head consumed this cycle
module fp_wb_rload_fifo #(
  parameter int unsigned width_p = 37,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned lg_els_lp = $clog2(els_p);

  // Extra MSB on each pointer separates full from empty when indices match.
  logic [lg_els_lp:0] wptr_r, rptr_r;
  logic [width_p-1:0] mem_r [els_p];
  logic full, empty, push, pop;

  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[lg_els_lp] != rptr_r[lg_els_lp])
              && (wptr_r[lg_els_lp-1:0] == rptr_r[lg_els_lp-1:0]);

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_r[rptr_r[lg_els_lp-1:0]];

  // A push into a full buffer is accepted when the head leaves the same
  // cycle; otherwise it is dropped.
  assign pop  = yumi_i & ~empty;
  assign push = v_i & (~full | pop);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + 1'b1;
      if (pop)  rptr_r <= rptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r[lg_els_lp-1:0]] <= data_i;
  end

  rload_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(v_i && full && !pop))
    else $error("remote load response dropped: buffer full");

endmodule

// File: rtl/fp_wb_arb.sv
// FP regfile write-back arbiter: merges float pipe, fdiv/fsqrt and remote
// float-load responses onto the single registered regfile write port.
// Ports:
//   clk_i, reset_n_i                      : clock, async active-low reset
//   float_v_i/data_i/rd_i, float_yumi_o   : float pipe result stream
//   fdiv_v_i/data_i/rd_i, fdiv_yumi_o     : fdiv/fsqrt result stream
//   rload_v_i/data_i/rd_i, rload_ready_o  : remote load responses (buffered)
//   w_v_o, w_addr_o, w_data_o             : registered regfile write
//   clear_v_o, clear_addr_o               : registered scoreboard clear
module fp_wb_arb
  import fp_wb_arb_pkg::*;
#(
  parameter int unsigned data_width_p       = 32,
  parameter int unsigned reg_addr_width_p   = 5,
  parameter int unsigned rload_els_p        = 2,
  parameter int unsigned starve_limit_p     = 4,
  parameter int unsigned starve_cnt_width_p = 3
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        float_v_i,
  input  logic [data_width_p-1:0]     float_data_i,
  input  logic [reg_addr_width_p-1:0] float_rd_i,
  output logic                        float_yumi_o,
  input  logic                        fdiv_v_i,
  input  logic [data_width_p-1:0]     fdiv_data_i,
  input  logic [reg_addr_width_p-1:0] fdiv_rd_i,
  output logic                        fdiv_yumi_o,
  input  logic                        rload_v_i,
  input  logic [data_width_p-1:0]     rload_data_i,
  input  logic [reg_addr_width_p-1:0] rload_rd_i,
  output logic                        rload_ready_o,
  output logic                        w_v_o,
  output logic [reg_addr_width_p-1:0] w_addr_o,
  output logic [data_width_p-1:0]     w_data_o,
  output logic                        clear_v_o,
  output logic [reg_addr_width_p-1:0] clear_addr_o
);

  typedef struct packed {
    logic [reg_addr_width_p-1:0] rd;
    logic [data_width_p-1:0]     data;
  } entry_t;

  localparam logic [starve_cnt_width_p-1:0] starve_limit_lp =
    starve_cnt_width_p'(starve_limit_p);

  entry_t     fifo_entry_li, fifo_entry_lo, grant_entry;
  logic       fifo_v_lo, fifo_ready_lo, fifo_yumi_li;
  fp_wb_src_e grant_src;

  logic [starve_cnt_width_p-1:0] float_cnt_r, fdiv_cnt_r;
  logic float_promoted, fdiv_promoted;

  assign fifo_entry_li = '{rd: rload_rd_i, data: rload_data_i};

  fp_wb_rload_fifo #(
    .width_p ($bits(entry_t)),
    .els_p   (rload_els_p)
  ) rload_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (rload_v_i),
    .data_i    (fifo_entry_li),
    .ready_o   (fifo_ready_lo),
    .v_o       (fifo_v_lo),
    .data_o    (fifo_entry_lo),
    .yumi_i    (fifo_yumi_li)
  );

  assign rload_ready_o  = fifo_ready_lo;
  assign float_promoted = (float_cnt_r == starve_limit_lp);
  assign fdiv_promoted  = (fdiv_cnt_r  == starve_limit_lp);

  always_comb begin
    grant_src = e_wb_none;
    if (!fifo_ready_lo && fifo_v_lo)     grant_src = e_wb_rload;
    else if (float_promoted && float_v_i) grant_src = e_wb_float;
    else if (fdiv_promoted && fdiv_v_i)   grant_src = e_wb_fdiv;
    else if (fifo_v_lo)                   grant_src = e_wb_rload;
    else if (float_v_i)                   grant_src = e_wb_float;
    else if (fdiv_v_i)                    grant_src = e_wb_fdiv;
  end

  always_comb begin
    grant_entry = '0;
    unique case (grant_src)
      e_wb_float: grant_entry = '{rd: float_rd_i, data: float_data_i};
      e_wb_fdiv:  grant_entry = '{rd: fdiv_rd_i,  data: fdiv_data_i};
      e_wb_rload: grant_entry = fifo_entry_lo;
      default:    grant_entry = '0;
    endcase
  end

  assign float_yumi_o = (grant_src == e_wb_float);
  assign fdiv_yumi_o  = (grant_src == e_wb_fdiv);
  assign fifo_yumi_li = (grant_src == e_wb_rload);

  // Counts consecutive denied cycles; saturates at the promotion threshold.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      float_cnt_r <= '0;
      fdiv_cnt_r  <= '0;
    end else begin
      if (float_v_i && !float_yumi_o)
        float_cnt_r <= float_promoted ? float_cnt_r : float_cnt_r + 1'b1;
      else
        float_cnt_r <= '0;
      if (fdiv_v_i && !fdiv_yumi_o)
        fdiv_cnt_r <= fdiv_promoted ? fdiv_cnt_r : fdiv_cnt_r + 1'b1;
      else
        fdiv_cnt_r <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_o        <= 1'b0;
      w_addr_o     <= '0;
      w_data_o     <= '0;
      clear_v_o    <= 1'b0;
      clear_addr_o <= '0;
    end else begin
      w_v_o     <= (grant_src != e_wb_none);
      clear_v_o <= fp_wb_clears(grant_src);
      if (grant_src != e_wb_none) begin
        w_addr_o <= grant_entry.rd;
        w_data_o <= grant_entry.data;
      end
      if (fp_wb_clears(grant_src)) clear_addr_o <= grant_entry.rd;
    end
  end

endmodule

// File: tb/tb_fp_wb_arb.sv
module tb_fp_wb_arb;
  import fp_wb_arb_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int ELS = 2;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          float_v_i, fdiv_v_i, rload_v_i;
  logic [DW-1:0] float_data_i, fdiv_data_i, rload_data_i;
  logic [AW-1:0] float_rd_i, fdiv_rd_i, rload_rd_i;
  logic          float_yumi_o, fdiv_yumi_o, rload_ready_o;
  logic          w_v_o, clear_v_o;
  logic [AW-1:0] w_addr_o, clear_addr_o;
  logic [DW-1:0] w_data_o;

  always #5 clk = ~clk;

  fp_wb_arb #(
    .data_width_p       (DW),
    .reg_addr_width_p   (AW),
    .rload_els_p        (ELS),
    .starve_limit_p     (LIM),
    .starve_cnt_width_p (3)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .float_v_i     (float_v_i),
    .float_data_i  (float_data_i),
    .float_rd_i    (float_rd_i),
    .float_yumi_o  (float_yumi_o),
    .fdiv_v_i      (fdiv_v_i),
    .fdiv_data_i   (fdiv_data_i),
    .fdiv_rd_i     (fdiv_rd_i),
    .fdiv_yumi_o   (fdiv_yumi_o),
    .rload_v_i     (rload_v_i),
    .rload_data_i  (rload_data_i),
    .rload_rd_i    (rload_rd_i),
    .rload_ready_o (rload_ready_o),
    .w_v_o         (w_v_o),
    .w_addr_o      (w_addr_o),
    .w_data_o      (w_data_o),
    .clear_v_o     (clear_v_o),
    .clear_addr_o  (clear_addr_o)
  );

  // Reference model: queue of pending loads, denied-cycle counts, and the
  // write/clear values the port should show.
  fp_wb_entry_s  q[$];
  int            fcnt, dcnt;
  logic          m_wv, m_clr;
  logic [AW-1:0] m_waddr, m_caddr;
  logic [DW-1:0] m_wdata;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_fy, last_dy, last_ready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic fp_wb_src_e model_grant();
    if (q.size() == ELS)          return e_wb_rload;
    if (float_v_i && fcnt >= LIM) return e_wb_float;
    if (fdiv_v_i && dcnt >= LIM)  return e_wb_fdiv;
    if (q.size() > 0)             return e_wb_rload;
    if (float_v_i)                return e_wb_float;
    if (fdiv_v_i)                 return e_wb_fdiv;
    return e_wb_none;
  endfunction

  task automatic model_reset();
    q.delete();
    fcnt = 0; dcnt = 0;
    m_wv = 0; m_clr = 0; m_waddr = '0; m_caddr = '0; m_wdata = '0;
  endtask

  // One clock: check grant mid-cycle, advance model at the edge, check the
  // registered outputs just after it.
  task automatic step();
    fp_wb_src_e   g;
    fp_wb_entry_s e;
    int           occ;
    @(negedge clk);
    g = model_grant();
    last_fy = float_yumi_o; last_dy = fdiv_yumi_o; last_ready = rload_ready_o;
    chk("float_yumi",  64'(float_yumi_o),  64'(g == e_wb_float));
    chk("fdiv_yumi",   64'(fdiv_yumi_o),   64'(g == e_wb_fdiv));
    chk("rload_ready", 64'(rload_ready_o), 64'(q.size() < ELS));
    @(posedge clk);
    occ = q.size();
    e = '0;
    case (g)
      e_wb_float: e = '{rd: float_rd_i, data: float_data_i};
      e_wb_fdiv:  e = '{rd: fdiv_rd_i,  data: fdiv_data_i};
      e_wb_rload: e = q.pop_front();
      default:    e = '0;
    endcase
    m_wv  = (g != e_wb_none);
    m_clr = (g == e_wb_fdiv) || (g == e_wb_rload);
    if (m_wv) begin m_waddr = e.rd; m_wdata = e.data; end
    if (m_clr) m_caddr = e.rd;
    if (rload_v_i && (occ < ELS || g == e_wb_rload))
      q.push_back('{rd: rload_rd_i, data: rload_data_i});
    fcnt = (float_v_i && g != e_wb_float) ? ((fcnt < LIM) ? fcnt + 1 : LIM) : 0;
    dcnt = (fdiv_v_i  && g != e_wb_fdiv)  ? ((dcnt < LIM) ? dcnt + 1 : LIM) : 0;
    #1;
    chk("w_v",     64'(w_v_o),     64'(m_wv));
    chk("w_addr",  64'(w_addr_o),  64'(m_waddr));
    chk("w_data",  64'(w_data_o),  64'(m_wdata));
    chk("clear_v", 64'(clear_v_o), 64'(m_clr));
    if (m_clr) chk("clear_addr", 64'(clear_addr_o), 64'(m_caddr));
  endtask

  task automatic set_float(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    float_v_i = v; float_rd_i = rd; float_data_i = d;
  endtask
  task automatic set_fdiv(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    fdiv_v_i = v; fdiv_rd_i = rd; fdiv_data_i = d;
  endtask
  task automatic set_rload(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    rload_v_i = v; rload_rd_i = rd; rload_data_i = d;
  endtask
  task automatic set_idle();
    set_float(0, '0, '0); set_fdiv(0, '0, '0); set_rload(0, '0, '0);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;
  endtask

  typedef struct {
    logic          fv, dv, rv;
    fp_wb_entry_s  fe, de, re;
    logic          exp_fy, exp_dy, exp_wv, exp_clr;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk_vec(
    input logic fv, input logic [AW-1:0] frd, input logic [DW-1:0] fd,
    input logic dv, input logic [AW-1:0] drd, input logic [DW-1:0] dd,
    input logic rv, input logic [AW-1:0] rrd, input logic [DW-1:0] rd,
    input logic efy, input logic edy, input logic ewv,
    input logic [AW-1:0] ewa, input logic [DW-1:0] ewd, input logic eclr);
    vec_t v;
    v.fv = fv; v.fe.rd = frd; v.fe.data = fd;
    v.dv = dv; v.de.rd = drd; v.de.data = dd;
    v.rv = rv; v.re.rd = rrd; v.re.data = rd;
    v.exp_fy = efy; v.exp_dy = edy; v.exp_wv = ewv;
    v.exp_waddr = ewa; v.exp_wdata = ewd; v.exp_clr = eclr;
    return v;
  endfunction

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Consecutive cycles from a fresh reset.
    tbl[0] = mk_vec(1, 3, 32'h3F800000, 0, 0, 0, 0, 0, 0,          1, 0, 1, 3, 32'h3F800000, 0);
    tbl[1] = mk_vec(0, 0, 0,            0, 0, 0, 1, 5, 32'h000000A5, 0, 0, 0, 3, 32'h3F800000, 0);
    tbl[2] = mk_vec(1, 6, 32'h40000000, 0, 0, 0, 0, 0, 0,          0, 0, 1, 5, 32'h000000A5, 1);
    tbl[3] = mk_vec(1, 6, 32'h40000000, 0, 0, 0, 0, 0, 0,          1, 0, 1, 6, 32'h40000000, 0);
    tbl[4] = mk_vec(0, 0, 0, 1, 9, 32'h41100000, 0, 0, 0,          0, 1, 1, 9, 32'h41100000, 1);
    tbl[5] = mk_vec(0, 0, 0,            0, 0, 0, 0, 0, 0,          0, 0, 0, 9, 32'h41100000, 0);

    reset_n_i = 1'b0;
    set_idle();
    model_reset();
    do_reset();
    chk("reset_w_v",        64'(w_v_o),         64'(0));
    chk("reset_w_addr",     64'(w_addr_o),      64'(0));
    chk("reset_w_data",     64'(w_data_o),      64'(0));
    chk("reset_clear_v",    64'(clear_v_o),     64'(0));
    chk("reset_clear_addr", 64'(clear_addr_o),  64'(0));
    chk("reset_ready",      64'(rload_ready_o), 64'(1));

    for (int i = 0; i < 6; i++) begin
      set_float(tbl[i].fv, tbl[i].fe.rd, tbl[i].fe.data);
      set_fdiv(tbl[i].dv, tbl[i].de.rd, tbl[i].de.data);
      set_rload(tbl[i].rv, tbl[i].re.rd, tbl[i].re.data);
      step();
      chk("tbl_fy",     64'(last_fy),   64'(tbl[i].exp_fy));
      chk("tbl_dy",     64'(last_dy),   64'(tbl[i].exp_dy));
      chk("tbl_wv",     64'(w_v_o),     64'(tbl[i].exp_wv));
      chk("tbl_waddr",  64'(w_addr_o),  64'(tbl[i].exp_waddr));
      chk("tbl_wdata",  64'(w_data_o),  64'(tbl[i].exp_wdata));
      chk("tbl_clear",  64'(clear_v_o), 64'(tbl[i].exp_clr));
    end

    // Starvation: a steady load stream denies float four times, then float wins.
    do_reset();
    set_rload(1, 1, 32'h100);
    step();
    set_float(1, 7, 32'h7777);
    for (int i = 0; i < 4; i++) begin
      set_rload(1, AW'(10 + i), 32'(i));
      step();
      chk("starve_deny", 64'(last_fy), 64'(0));
    end
    set_rload(1, 14, 32'h14);
    step();
    chk("starve_grant", 64'(last_fy), 64'(1));
    // Counter restarted: float loses to the (full, then non-empty) buffer.
    set_float(1, 8, 32'h8888);
    set_rload(0, 0, 0);
    step(); chk("starve_after_full", 64'(last_fy), 64'(0));
    step(); chk("starve_cnt_cleared", 64'(last_fy), 64'(0));
    step(); chk("starve_drained", 64'(last_fy), 64'(1));
    set_idle();
    step();

    // Both promoted, then buffer filled while the port is held by compute.
    do_reset();
    set_rload(1, 10, 32'hA10);
    step();
    set_float(1, 21, 32'h2121);
    set_fdiv(1, 22, 32'h2222);
    for (int i = 1; i <= 4; i++) begin
      set_rload(1, AW'(10 + i), 32'hA10 + 32'(i));
      step();
      chk("prom_build_fy", 64'(last_fy), 64'(0));
      chk("prom_build_dy", 64'(last_dy), 64'(0));
    end
    set_rload(0, 0, 0);
    step();
    chk("both_prom_float", 64'(last_fy), 64'(1));
    chk("both_prom_no_fdiv", 64'(last_dy), 64'(0));
    set_float(1, 24, 32'h2424);
    set_rload(1, 15, 32'hA15);
    step();
    chk("fdiv_next", 64'(last_dy), 64'(1));
    chk("fdiv_clear_v", 64'(clear_v_o), 64'(1));
    chk("fdiv_clear_addr", 64'(clear_addr_o), 64'(22));
    set_fdiv(1, 23, 32'h2323);
    set_rload(1, 16, 32'hA16);
    step();
    chk("full_ready_low", 64'(last_ready), 64'(0));
    chk("full_head_fy", 64'(last_fy), 64'(0));
    chk("full_head_dy", 64'(last_dy), 64'(0));
    chk("full_head_addr", 64'(w_addr_o), 64'(14));
    set_rload(1, 17, 32'hA17);
    step();
    chk("full_kept", 64'(last_ready), 64'(0));
    chk("full_next_addr", 64'(w_addr_o), 64'(15));

    // Mid-stream reset with two loads queued and a write in flight.
    #1;
    reset_n_i = 1'b0;
    set_idle();
    model_reset();
    #1;
    chk("async_w_v",     64'(w_v_o),     64'(0));
    chk("async_clear_v", 64'(clear_v_o), 64'(0));
    chk("async_w_addr",  64'(w_addr_o),  64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;
    chk("post_reset_ready", 64'(rload_ready_o), 64'(1));
    step();
    set_float(1, 2, 32'h0202);
    step();
    chk("post_reset_empty", 64'(last_fy), 64'(1));
    set_idle();
    step();

    // Randomized traffic against the model, respecting the hold protocol.
    do_reset();
    last_fy = 1; last_dy = 1;
    for (int n = 0; n < 600; n++) begin
      if (!(float_v_i && !last_fy))
        set_float(($urandom_range(0, 9) < 6), AW'($urandom), $urandom);
      if (!(fdiv_v_i && !last_dy))
        set_fdiv(($urandom_range(0, 9) < 3), AW'($urandom), $urandom);
      set_rload(($urandom_range(0, 9) < 5), AW'($urandom), $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
